// File: rtl/qoi_rgb444_encoder.sv
// Streaming QOI-style byte encoder for RGB444 pixels (RUN / INDEX / DIFF / LUMA ops).
// Optional colour index table enabled by defining QOI_ENC_INDEX_EN.
module qoi_rgb444_encoder #(
  parameter int          MAX_RUN    = 64,
  parameter logic [11:0] INIT_PIXEL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] in_rgb,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready
);

  localparam logic [6:0] MAX_RUN_L = 7'(MAX_RUN);

  function automatic logic [7:0] run_byte(input logic [6:0] len);
    logic [6:0] len_m1;
    len_m1 = len - 7'd1;
    return {2'b11, len_m1[5:0]};
  endfunction

`ifdef QOI_ENC_INDEX_EN
  function automatic logic [5:0] px_hash(input logic [11:0] px);
    logic [7:0] sum;
    sum = 8'd3 * {4'd0, px[11:8]} + 8'd5 * {4'd0, px[7:4]} + 8'd7 * {4'd0, px[3:0]};
    return sum[5:0];
  endfunction
`endif

  logic [11:0] prev_r, prev_n;
  logic [6:0]  run_r, run_n;
  logic [7:0]  q_byte_r [3];
  logic [7:0]  q_byte_n [3];
  logic [2:0]  q_last_r, q_last_n;
  logic [1:0]  cnt_r, cnt_n;
  logic        out_valid_r, in_ready_r;

  logic        accept_s, same_px_s, pop_s;
  logic [3:0]  dr_s, dg_s, db_s, dr2_s, dg2_s, db2_s;
  logic        diff_ok_s, op_two_s;
  logic [7:0]  op0_s, op1_s;
  logic [7:0]  pb_s [3];
  logic [1:0]  pn_s;
  logic        push_last_s;

  assign accept_s  = in_valid & in_ready_r;
  assign same_px_s = (in_rgb == prev_r);
  assign pop_s     = (cnt_r != 2'd0) & out_ready;

  assign dr_s  = in_rgb[11:8] - prev_r[11:8];
  assign dg_s  = in_rgb[7:4]  - prev_r[7:4];
  assign db_s  = in_rgb[3:0]  - prev_r[3:0];
  // A delta fits DIFF (-2..+1) exactly when delta+2 lands in 0..3.
  assign dr2_s = dr_s + 4'd2;
  assign dg2_s = dg_s + 4'd2;
  assign db2_s = db_s + 4'd2;
  assign diff_ok_s = (dr2_s[3:2] == 2'b00) && (dg2_s[3:2] == 2'b00) && (db2_s[3:2] == 2'b00);

`ifdef QOI_ENC_INDEX_EN
  logic [11:0] tbl_r [64];
  logic [63:0] idx_valid_r, idx_valid_n;
  logic [5:0]  hash_s;
  logic        idx_hit_s, tbl_we_s;

  assign hash_s    = px_hash(in_rgb);
  assign idx_hit_s = idx_valid_r[hash_s] && (tbl_r[hash_s] == in_rgb);
  assign tbl_we_s  = accept_s & ~same_px_s;

  // Table contents need no reset: every read is qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (tbl_we_s) tbl_r[hash_s] <= in_rgb;
  end

  // Valid bits: set on write, cleared wholesale at frame end (clear wins).
  always_comb begin
    idx_valid_n = idx_valid_r;
    if (accept_s && in_last) begin
      idx_valid_n = 64'd0;
    end else if (tbl_we_s) begin
      idx_valid_n[hash_s] = 1'b1;
    end else begin
      idx_valid_n = idx_valid_r;
    end
  end

  // Valid-bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_valid_r <= 64'd0;
    else     idx_valid_r <= idx_valid_n;
  end
`endif

  // Op selection for a pixel that differs from prev.
  always_comb begin
    op0_s    = 8'h00;
    op1_s    = 8'h00;
    op_two_s = 1'b0;
`ifdef QOI_ENC_INDEX_EN
    if (idx_hit_s) begin
      op0_s = {2'b00, hash_s};
    end else
`endif
    if (diff_ok_s) begin
      op0_s = {2'b01, dr2_s[1:0], dg2_s[1:0], db2_s[1:0]};
    end else begin
      op0_s    = {4'b1000, dg_s};
      op1_s    = {dr_s - dg_s, db_s - dg_s};
      op_two_s = 1'b1;
    end
  end

  // Pixel acceptance: build up to three bytes and update run/prev.
  always_comb begin
    pb_s        = '{default: 8'h00};
    pn_s        = 2'd0;
    push_last_s = 1'b0;
    run_n       = run_r;
    prev_n      = prev_r;
    if (accept_s) begin
      if (same_px_s) begin
        run_n = run_r + 7'd1;
        if (run_n == MAX_RUN_L) begin
          pb_s[pn_s] = run_byte(run_n);
          pn_s       = pn_s + 2'd1;
          run_n      = 7'd0;
        end else begin
          pn_s = 2'd0;
        end
      end else begin
        if (run_r != 7'd0) begin
          pb_s[pn_s] = run_byte(run_r);
          pn_s       = pn_s + 2'd1;
        end else begin
          pn_s = 2'd0;
        end
        pb_s[pn_s] = op0_s;
        pn_s       = pn_s + 2'd1;
        if (op_two_s) begin
          pb_s[pn_s] = op1_s;
          pn_s       = pn_s + 2'd1;
        end else begin
          op_two_s_unused_guard();
        end
        run_n  = 7'd0;
        prev_n = in_rgb;
      end
      // Frame end: flush the run and restore the per-frame start state.
      if (in_last) begin
        if (run_n != 7'd0) begin
          pb_s[pn_s] = run_byte(run_n);
          pn_s       = pn_s + 2'd1;
        end else begin
          push_last_s = 1'b1;
        end
        push_last_s = 1'b1;
        run_n       = 7'd0;
        prev_n      = INIT_PIXEL;
      end else begin
        push_last_s = 1'b0;
      end
    end else begin
      run_n = run_r;
    end
  end

  function automatic void op_two_s_unused_guard();
  endfunction

  // Byte queue: loads only when empty, otherwise shifts out one byte per pop.
  always_comb begin
    cnt_n    = cnt_r;
    q_byte_n = q_byte_r;
    q_last_n = q_last_r;
    if (accept_s) begin
      q_byte_n = pb_s;
      cnt_n    = pn_s;
      case ({push_last_s, pn_s})
        3'b101:  q_last_n = 3'b001;
        3'b110:  q_last_n = 3'b010;
        3'b111:  q_last_n = 3'b100;
        default: q_last_n = 3'b000;
      endcase
    end else if (pop_s) begin
      q_byte_n[0] = q_byte_r[1];
      q_byte_n[1] = q_byte_r[2];
      q_byte_n[2] = 8'h00;
      q_last_n    = {1'b0, q_last_r[2:1]};
      cnt_n       = cnt_r - 2'd1;
    end else begin
      cnt_n = cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r      <= INIT_PIXEL;
      run_r       <= 7'd0;
      q_byte_r    <= '{default: 8'h00};
      q_last_r    <= 3'b000;
      cnt_r       <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      prev_r      <= prev_n;
      run_r       <= run_n;
      q_byte_r    <= q_byte_n;
      q_last_r    <= q_last_n;
      cnt_r       <= cnt_n;
      out_valid_r <= (cnt_n != 2'd0);
      in_ready_r  <= (cnt_n == 2'd0);
    end
  end

  assign out_byte  = q_byte_r[0];
  assign out_last  = q_last_r[0];
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule
